tone_sequencer: RTL and testbench

//  Parametrised successor to the single-beep tone generator. On a play trigger it

---
 rtl/tone_sequencer_if.sv | 24 ++
 rtl/tone_sequencer.sv | 155 +++++++++++++++
 tb/tb_tone_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tone_sequencer_if.sv
// Trigger/status/sample bundle between audio_trigger, tone_sequencer and the audio-core write FIFO.
interface tone_sequencer_if #(
  parameter int SAMPLE_W = 32
);
  logic                play_trigger;
  logic                stop;
  logic                audio_out_allowed;
  logic                write_out;
  logic [SAMPLE_W-1:0] left_out;
  logic [SAMPLE_W-1:0] right_out;
  logic                busy;
  logic [3:0]          note_idx;
  logic                done_pulse;

  modport master (
    output play_trigger, stop, audio_out_allowed,
    input  write_out, left_out, right_out, busy, note_idx, done_pulse
  );

  modport slave (
    input  play_trigger, stop, audio_out_allowed,
    output write_out, left_out, right_out, busy, note_idx, done_pulse
  );
endinterface

// File: rtl/tone_sequencer.sv
// Melody player: NUM_NOTES square-wave notes with gaps; first sample the cycle after play_trigger,
// time advances only on accepted samples (audio_out_allowed). TONE_SEQ_DECAY_EN adds a 4-band decay.
module tone_sequencer #(
  parameter int SAMPLE_W  = 32,
  parameter int NUM_NOTES = 4,
  parameter int NOTE_DUR  = 12000,
  parameter int GAP_DUR   = 1200,
  parameter int HP_W      = 9,
  parameter logic [NUM_NOTES*HP_W-1:0] NOTE_HP = {9'd95, 9'd0, 9'd120, 9'd142}
) (
  input  logic             clk,
  input  logic             reset,
  tone_sequencer_if.slave  io
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  localparam logic [15:0] NOTE_LAST = 16'(NOTE_DUR - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_DUR - 1);
  localparam logic [3:0]  LAST_NOTE = 4'(NUM_NOTES - 1);
  localparam logic signed [SAMPLE_W-1:0] AMP_HI = {4'b0000, {(SAMPLE_W-4){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] AMP_LO = {4'b1111, {(SAMPLE_W-4){1'b0}}};

  state_e      state_q, state_d;
  logic [3:0]  note_idx_q, note_idx_d;
  logic [15:0] time_cnt_q, time_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] wave_cnt_q, wave_cnt_d;
  logic        tone_state_q, tone_state_d;
  logic        done_q, done_d;

  logic [HP_W-1:0]            hp;
  logic [15:0]                hp_last;
  logic                       last_note;
  logic signed [SAMPLE_W-1:0] tone_raw;
  logic signed [SAMPLE_W-1:0] tone_amp;

  assign hp        = NOTE_HP[int'(note_idx_q)*HP_W +: HP_W];
  assign hp_last   = 16'(hp) - 16'd1;
  assign last_note = (note_idx_q == LAST_NOTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      note_idx_q   <= '0;
      time_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      wave_cnt_q   <= '0;
      tone_state_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      note_idx_q   <= note_idx_d;
      time_cnt_q   <= time_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      wave_cnt_q   <= wave_cnt_d;
      tone_state_q <= tone_state_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    note_idx_d   = note_idx_q;
    time_cnt_d   = time_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    wave_cnt_d   = wave_cnt_q;
    tone_state_d = tone_state_q;
    done_d       = 1'b0;
    // stop and trigger both wipe the counters; they differ only in the state they land in
    if (io.stop || io.play_trigger) begin
      state_d      = io.stop ? IDLE : PLAY;
      note_idx_d   = '0;
      time_cnt_d   = '0;
      gap_cnt_d    = '0;
      wave_cnt_d   = '0;
      tone_state_d = 1'b0;
    end else if (io.audio_out_allowed) begin
      case (state_q)
        PLAY: begin
          if (hp != '0) begin
            if (wave_cnt_q == hp_last) begin
              wave_cnt_d   = '0;
              tone_state_d = ~tone_state_q;
            end else begin
              wave_cnt_d = wave_cnt_q + 16'd1;
            end
          end
          if (time_cnt_q == NOTE_LAST) begin
            time_cnt_d   = '0;
            wave_cnt_d   = '0;
            tone_state_d = 1'b0;
            if (GAP_DUR != 0) begin
              state_d   = GAP;
              gap_cnt_d = '0;
            end else if (last_note) begin
              state_d    = IDLE;
              note_idx_d = '0;
              done_d     = 1'b1;
            end else begin
              note_idx_d = note_idx_q + 4'd1;
            end
          end else begin
            time_cnt_d = time_cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            if (last_note) begin
              state_d    = IDLE;
              note_idx_d = '0;
              done_d     = 1'b1;
            end else begin
              state_d    = PLAY;
              note_idx_d = note_idx_q + 4'd1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // phase 0 of every note is the high half-cycle
  assign tone_raw = tone_state_q ? AMP_LO : AMP_HI;

`ifdef TONE_SEQ_DECAY_EN
  localparam logic [15:0] BAND1 = 16'(NOTE_DUR / 4);
  localparam logic [15:0] BAND2 = 16'(NOTE_DUR / 2);
  localparam logic [15:0] BAND3 = 16'((3 * NOTE_DUR) / 4);
  logic [1:0] band;

  always_comb begin
    band = 2'd3;
    if (time_cnt_q < BAND1)      band = 2'd0;
    else if (time_cnt_q < BAND2) band = 2'd1;
    else if (time_cnt_q < BAND3) band = 2'd2;
  end

  assign tone_amp = tone_raw >>> band;
`else
  assign tone_amp = tone_raw;
`endif

  assign io.left_out   = (state_q == PLAY && hp != '0) ? tone_amp : '0;
  assign io.right_out  = io.left_out;
  assign io.write_out  = (state_q != IDLE) && io.audio_out_allowed;
  assign io.busy       = (state_q != IDLE);
  assign io.note_idx   = note_idx_q;
  assign io.done_pulse = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: 2-note melody (tone hp=2, then rest), NOTE_DUR=8, GAP_DUR=2.
module tb_tone_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  tone_sequencer_if #(.SAMPLE_W(32)) bus ();

  tone_sequencer #(
    .SAMPLE_W(32), .NUM_NOTES(2), .NOTE_DUR(8), .GAP_DUR(2), .HP_W(9),
    .NOTE_HP({9'd0, 9'd2})
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus)
  );

  // Expected sample k of the 20-sample melody: 8 tone, 2 gap, 8 rest, 2 gap.
  function automatic logic [31:0] exp_sample(input int k);
    logic signed [31:0] v;
    int sh;
    if (k >= 8) return 32'h0;
    v = ((k / 2) % 2 == 0) ? 32'sh0FFFFFFF : 32'shF0000000;
`ifdef TONE_SEQ_DECAY_EN
    sh = k / 2;
`else
    sh = 0;
`endif
    return v >>> sh;
  endfunction

  task automatic tick(input logic trig, input logic stp, input logic alw);
    @(posedge clk);
    #1;
    bus.play_trigger      = trig;
    bus.stop              = stp;
    bus.audio_out_allowed = alw;
    #1;
  endtask

  task automatic test_reset();
    int dones;
    reset = 1'b1;
    tick(0, 0, 1);
    tick(0, 0, 1);
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    total++; if (bus.left_out !== 32'h0) $display("FAIL reset_left got %h want 0", bus.left_out); else passed++;
    total++; if (bus.write_out !== 1'b0) $display("FAIL reset_write got %b want 0", bus.write_out); else passed++;
    total++; if (bus.done_pulse !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done_pulse); else passed++;
    total++; if (bus.note_idx !== 4'd0) $display("FAIL reset_note_idx got %0d want 0", bus.note_idx); else passed++;
    reset = 1'b0;
    tick(1, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 1);
    reset = 1'b1;
    tick(0, 0, 1);
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_mid_busy got %b want 0", bus.busy); else passed++;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1);
      if (bus.done_pulse === 1'b1) dones++;
    end
    total++; if (dones != 0) $display("FAIL reset_mid_done got %0d want 0", dones); else passed++;
  endtask

  task automatic test_basic();
    tick(1, 0, 1);
    total++; if (bus.busy !== 1'b0) $display("FAIL basic_trig_cycle_busy got %b want 0", bus.busy); else passed++;
    for (int k = 0; k < 20; k++) begin
      tick(0, 0, 1);
      total++; if (bus.left_out !== exp_sample(k))
        $display("FAIL basic_left k=%0d got %h want %h", k, bus.left_out, exp_sample(k)); else passed++;
      total++; if (bus.right_out !== exp_sample(k))
        $display("FAIL basic_right k=%0d got %h want %h", k, bus.right_out, exp_sample(k)); else passed++;
      total++; if (bus.write_out !== 1'b1 || bus.busy !== 1'b1 || bus.done_pulse !== 1'b0)
        $display("FAIL basic_status k=%0d got w=%b b=%b d=%b want 1 1 0", k, bus.write_out, bus.busy,
                 bus.done_pulse); else passed++;
      total++; if (bus.note_idx !== ((k < 10) ? 4'd0 : 4'd1))
        $display("FAIL basic_note_idx k=%0d got %0d want %0d", k, bus.note_idx, (k < 10) ? 0 : 1); else passed++;
    end
    tick(0, 0, 1);
    total++; if (bus.done_pulse !== 1'b1) $display("FAIL basic_done got %b want 1", bus.done_pulse); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL basic_end_busy got %b want 0", bus.busy); else passed++;
    tick(0, 0, 1);
    total++; if (bus.done_pulse !== 1'b0) $display("FAIL basic_done_width got %b want 0", bus.done_pulse); else passed++;
  endtask

  task automatic test_throttle();
    int k, busy_cycles, dones;
    logic alw;
    k = 0; busy_cycles = 0; dones = 0;
    tick(1, 0, 1);
    for (int j = 0; j < 100; j++) begin
      alw = ((j % 2) == 1);
      tick(0, 0, alw);
      if (bus.done_pulse === 1'b1) dones++;
      if (bus.busy !== 1'b1) break;
      busy_cycles++;
      if (alw) begin
        total++; if (bus.left_out !== exp_sample(k) || bus.write_out !== 1'b1)
          $display("FAIL throttle_sample k=%0d got %h w=%b want %h w=1", k, bus.left_out, bus.write_out,
                   exp_sample(k)); else passed++;
        k++;
      end else begin
        total++; if (bus.write_out !== 1'b0)
          $display("FAIL throttle_write_blocked cycle=%0d got %b want 0", j, bus.write_out); else passed++;
      end
    end
    total++; if (busy_cycles != 40) $display("FAIL throttle_duration got %0d want 40", busy_cycles); else passed++;
    total++; if (k != 20) $display("FAIL throttle_samples got %0d want 20", k); else passed++;
    total++; if (dones != 1) $display("FAIL throttle_done_count got %0d want 1", dones); else passed++;
  endtask

  task automatic test_retrigger();
    int dones;
    dones = 0;
    tick(1, 0, 1);
    for (int k = 0; k < 14; k++) begin
      tick(0, 0, 1);
      if (bus.done_pulse === 1'b1) dones++;
    end
    total++; if (bus.note_idx !== 4'd1) $display("FAIL retrig_pre_note got %0d want 1", bus.note_idx); else passed++;
    tick(1, 0, 1);
    for (int k = 0; k < 20; k++) begin
      tick(0, 0, 1);
      if (bus.done_pulse === 1'b1) dones++;
      total++; if (bus.left_out !== exp_sample(k) || bus.note_idx !== ((k < 10) ? 4'd0 : 4'd1))
        $display("FAIL retrig_replay k=%0d got %h n=%0d want %h n=%0d", k, bus.left_out, bus.note_idx,
                 exp_sample(k), (k < 10) ? 0 : 1); else passed++;
    end
    tick(0, 0, 1);
    if (bus.done_pulse === 1'b1) dones++;
    total++; if (bus.busy !== 1'b0) $display("FAIL retrig_end_busy got %b want 0", bus.busy); else passed++;
    total++; if (dones != 1) $display("FAIL retrig_done_count got %0d want 1", dones); else passed++;
  endtask

  task automatic test_stop();
    int dones;
    dones = 0;
    tick(1, 0, 1);
    for (int k = 0; k < 8; k++) tick(0, 0, 1);
    tick(0, 1, 1);
    total++; if (bus.busy !== 1'b1 || bus.left_out !== 32'h0)
      $display("FAIL stop_in_gap got b=%b %h want b=1 0", bus.busy, bus.left_out); else passed++;
    tick(0, 0, 1);
    total++; if (bus.busy !== 1'b0 || bus.left_out !== 32'h0 || bus.write_out !== 1'b0)
      $display("FAIL stop_idle got b=%b %h w=%b want 0 0 0", bus.busy, bus.left_out, bus.write_out); else passed++;
    if (bus.done_pulse === 1'b1) dones++;
    for (int i = 0; i < 24; i++) begin
      tick(0, 0, 1);
      if (bus.done_pulse === 1'b1) dones++;
    end
    total++; if (dones != 0) $display("FAIL stop_no_done got %0d want 0", dones); else passed++;
    tick(1, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(1, 1, 1);
    tick(0, 0, 1);
    total++; if (bus.busy !== 1'b0 || bus.note_idx !== 4'd0)
      $display("FAIL stop_trig_same got b=%b n=%0d want 0 0", bus.busy, bus.note_idx); else passed++;
  endtask

  task automatic test_stall();
    tick(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0);
      total++; if (bus.busy !== 1'b1 || bus.write_out !== 1'b0 || bus.left_out !== exp_sample(0))
        $display("FAIL stall_hold i=%0d got b=%b w=%b %h want 1 0 %h", i, bus.busy, bus.write_out,
                 bus.left_out, exp_sample(0)); else passed++;
    end
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1);
      total++; if (bus.left_out !== exp_sample(k) || bus.write_out !== 1'b1)
        $display("FAIL stall_resume k=%0d got %h w=%b want %h w=1", k, bus.left_out, bus.write_out,
                 exp_sample(k)); else passed++;
    end
    tick(0, 1, 1);
    tick(0, 0, 1);
    total++; if (bus.busy !== 1'b0) $display("FAIL stall_stop_busy got %b want 0", bus.busy); else passed++;
  endtask

  initial begin
    bus.play_trigger      = 1'b0;
    bus.stop              = 1'b0;
    bus.audio_out_allowed = 1'b1;
    test_reset();
    test_basic();
    test_throttle();
    test_retrigger();
    test_stop();
    test_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t passed=%0d total=%0d", $time, passed, total);
    $fatal(1, "watchdog");
  end
endmodule
